cla_serial_subtractor: RTL and testbench

- Multi-cycle subtractor computing DIFF = A − B as A + ~B + 1.
- Uses one BLOCK-bit carry-lookahead slice, reused once per cycle, least-significant slice first.
- Built in the datapath + controller style: a controller FSM sequences a datapath holding operand and result shift registers.
- Completes the adder family with the subtract direction; a start/done handshake hooks it to upstream sequencers.

---
 rtl/cla_pkg.sv | 19 +
 rtl/cla_serial_subtractor_if.sv | 34 +++
 rtl/cla_block.sv | 50 +++++
 rtl/cla_serial_subtractor.sv | 133 +++++++++++++
 tb/tb_cla_serial_subtractor.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared types and constants for the serial carry-lookahead subtractor.
// Holds the controller state encoding, default geometry and the counter-width helper.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLOCK = 4;

  // Never returns 0, so a single-slice build still gets a 1-bit counter.
  function automatic int clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// Optional ovf signal exists only when SUB_OVERFLOW_EN is defined.
interface cla_serial_subtractor_if #(
  parameter int WIDTH = cla_pkg::DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
`ifdef SUB_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
`ifdef SUB_OVERFLOW_EN
    input  ovf,
`endif
    input  busy, done, diff, borrow, zero
  );

  modport slave (
    input  start, a, b,
`ifdef SUB_OVERFLOW_EN
    output ovf,
`endif
    output busy, done, diff, borrow, zero
  );

endinterface

// File: rtl/cla_block.sv
// BLOCK-bit carry-lookahead slice: sum, group generate/propagate and carry-out.
// Purely combinational, no state and no flow control.
module cla_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] x,
  input  logic [BLOCK-1:0] y,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             gg,
  output logic             gp,
  output logic             cout
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  assign g = x & y;
  assign p = x ^ y;

  // Each carry is a flat sum of products of g/p/cin, never a ripple of c[i].
  always_comb begin
    logic term;
    term = 1'b0;
    c    = '0;
    gg   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
      term = cin;
      for (int k = 0; k <= i; k++) term = term & p[k];
      c[i+1] = c[i+1] | term;
    end
    for (int j = 0; j < BLOCK; j++) begin
      term = g[j];
      for (int k = j + 1; k < BLOCK; k++) term = term & p[k];
      gg = gg | term;
    end
  end

  assign gp   = &p;
  assign cout = c[BLOCK];
  assign sum  = p ^ c[BLOCK-1:0];

endmodule

// File: rtl/cla_serial_subtractor.sv
// Serial A-B = A+~B+1 using one lookahead slice per cycle, LS slice first (SUB_OVERFLOW_EN adds ovf).
// Latency WIDTH/BLOCK RUN cycles then a one-cycle done; start is ignored while busy.
module cla_serial_subtractor
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cla_serial_subtractor_if.slave  bus
);

  localparam int NSLICE = WIDTH / BLOCK;
  localparam int CW     = clog2(NSLICE);

  if (WIDTH % BLOCK != 0) begin : g_geom_chk
    $fatal(1, "cla_serial_subtractor: WIDTH must be a multiple of BLOCK");
  end

  state_t state, state_nxt;
  logic   capture, step, last;

  logic [WIDTH-1:0]       a_sh, b_sh, res, res_nxt, diff_q;
  logic [WIDTH+BLOCK-1:0] res_cat;
  logic [CW-1:0]          cnt;
  logic                   carry, carry_nxt, borrow_q, zero_q;
  logic [BLOCK-1:0]       s_sum;
  logic                   s_gg, s_gp, s_cout;
`ifdef SUB_OVERFLOW_EN
  logic                   sign_a, sign_b, ovf_q;
`endif

  cla_block #(.BLOCK(BLOCK)) u_slice (
    .x    (a_sh[BLOCK-1:0]),
    .y    (b_sh[BLOCK-1:0]),
    .cin  (carry),
    .sum  (s_sum),
    .gg   (s_gg),
    .gp   (s_gp),
    .cout (s_cout)
  );

  // New slice enters at the top; after NSLICE steps the LS slice sits at bit 0.
  assign res_cat   = {s_sum, res};
  assign res_nxt   = res_cat[WIDTH+BLOCK-1:BLOCK];
  assign carry_nxt = s_gg | (s_gp & carry);
  assign last      = (cnt == CW'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          capture   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          capture   = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else if (capture) begin
      a_sh  <= bus.a;
      b_sh  <= ~bus.b;
      carry <= 1'b1;
      cnt   <= '0;
`ifdef SUB_OVERFLOW_EN
      sign_a <= bus.a[WIDTH-1];
      sign_b <= bus.b[WIDTH-1];
`endif
    end else if (step) begin
      a_sh  <= a_sh >> BLOCK;
      b_sh  <= b_sh >> BLOCK;
      res   <= res_nxt;
      carry <= carry_nxt;
      cnt   <= cnt + 1'b1;
      // Results are published on the edge into DONE and then held.
      if (last) begin
        diff_q   <= res_nxt;
        borrow_q <= ~s_cout;
        zero_q   <= (res_nxt == '0);
`ifdef SUB_OVERFLOW_EN
        ovf_q    <= (sign_a != sign_b) && (res_nxt[WIDTH-1] != sign_a);
`endif
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.zero   = zero_q;
`ifdef SUB_OVERFLOW_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// Directed bench for cla_serial_subtractor: arithmetic reference model plus literal checks.
module tb_cla_serial_subtractor;
  import cla_pkg::*;

  localparam int W  = 16;
  localparam int B  = 4;
  localparam int NS = W / B;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_serial_subtractor_if #(.WIDTH(W)) bus ();

  cla_serial_subtractor #(.WIDTH(W), .BLOCK(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted start yields a-b mod 2^W exactly NS cycles later.
  int         left = 0;
  logic       m_done = 1'b0, m_borrow = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] m_diff = '0, p_diff = '0;
  logic       p_borrow = 1'b0, p_zero = 1'b0, p_ovf = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      left <= 0; m_done <= 1'b0; m_diff <= '0;
      m_borrow <= 1'b0; m_zero <= 1'b0; m_ovf <= 1'b0;
    end else if (left > 0) begin
      left   <= left - 1;
      m_done <= (left == 1);
      if (left == 1) begin
        m_diff <= p_diff; m_borrow <= p_borrow; m_zero <= p_zero; m_ovf <= p_ovf;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        p_diff   <= bus.a - bus.b;
        p_borrow <= (bus.a < bus.b);
        p_zero   <= (bus.a == bus.b);
        p_ovf    <= (bus.a[W-1] != bus.b[W-1]) && (((bus.a - bus.b) >> (W-1)) != {15'd0, bus.a[W-1]});
        left     <= NS;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check1("busy", bus.busy, left > 0);
      check1("done", bus.done, m_done);
      check("diff", bus.diff, m_diff);
      check1("borrow", bus.borrow, m_borrow);
      check1("zero", bus.zero, m_zero);
`ifdef SUB_OVERFLOW_EN
      check1("ovf", bus.ovf, m_ovf);
`endif
    end
  end

  // Drives start for one cycle and waits (bounded) for done; sits on the done cycle on return.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int busy_cycles);
    bit seen;
    seen = 1'b0;
    busy_cycles = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.b = bv;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_cycles++;
      if (bus.done) seen = 1'b1;
    end
    check1("done_timeout", seen, 1'b1);
  endtask

  initial begin
    int bc;
    bit seen;
    int dones;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;

    @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    check1("rst_busy", bus.busy, 1'b0);
    check("rst_diff", bus.diff, 16'h0000);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0234, bc);
    check("busy_len", 16'(bc), 16'd4);
    check("sub_diff", bus.diff, 16'h1000);
    check("model_diff", m_diff, 16'h1000);
    check1("sub_borrow", bus.borrow, 1'b0);
    @(negedge clk);
    check1("done_one_pulse", bus.done, 1'b0);

    run_op(16'h0000, 16'h0001, bc);
    check("wrap_diff", bus.diff, 16'hFFFF);
    check1("wrap_borrow", bus.borrow, 1'b1);
    check1("model_borrow", m_borrow, 1'b1);
    check1("wrap_zero", bus.zero, 1'b0);

    run_op(16'hA5A5, 16'hA5A5, bc);
    check("eq_diff", bus.diff, 16'h0000);
    check1("eq_zero", bus.zero, 1'b1);
    check1("eq_borrow", bus.borrow, 1'b0);
    repeat (10) @(negedge clk);
    check("hold_diff", bus.diff, 16'h0000);
    check1("hold_zero", bus.zero, 1'b1);

    // Second start arrives mid-run and must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0010; bus.b = 16'h0001;
    seen = 1'b0;
    for (int i = 1; i < 20 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 3) begin bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; end
      if (bus.done) seen = 1'b1;
    end
    check1("busy_done_seen", seen, 1'b1);
    check("busy_diff", bus.diff, 16'h000F);
    // Back-to-back start taken in the done cycle.
    bus.start = 1'b1; bus.a = 16'h0005; bus.b = 16'h0003;
    seen = 1'b0;
    bc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) bc++;
      if (bus.done) seen = 1'b1;
    end
    check1("b2b_done_seen", seen, 1'b1);
    check("b2b_len", 16'(bc), 16'd4);
    check("b2b_diff", bus.diff, 16'h0002);

    // Reset during the second RUN cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h4321; bus.b = 16'h0101;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check1("midrst_busy", bus.busy, 1'b0);
    check1("midrst_done", bus.done, 1'b0);
    check("midrst_diff", bus.diff, 16'h0000);
    rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midrst_no_done", 16'(dones), 16'd0);

`ifdef SUB_OVERFLOW_EN
    run_op(16'h8000, 16'h0001, bc);
    check("ovf_diff", bus.diff, 16'h7FFF);
    check1("ovf_set", bus.ovf, 1'b1);
    check1("ovf_borrow", bus.borrow, 1'b0);
    check1("model_ovf", m_ovf, 1'b1);
    run_op(16'h0003, 16'h0005, bc);
    check("novf_diff", bus.diff, 16'hFFFE);
    check1("novf_clr", bus.ovf, 1'b0);
    check1("novf_borrow", bus.borrow, 1'b1);
`endif

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
